ex_mem_skid_stage: RTL and testbench

//  EX->MEM pipeline boundary directly downstream of the 32-bit ALU. Captures ALU result,

---
 rtl/ex_mem_skid_stage.sv | 175 +++++++++++++++++
 tb/tb_ex_mem_skid_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with a 2-entry skid buffer so in_ready never depends on out_ready.
// Optional stall counter enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_skid_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_zero,
  input  logic [DATA_WIDTH-1:0] in_store_data,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_regwrite,
  input  logic                  in_memread,
  input  logic                  in_memwrite,
  input  logic                  in_branch,
  input  logic                  in_bne,
`ifdef EX_MEM_STALL_CNT_EN
  output logic [31:0]           stall_count,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic [DATA_WIDTH-1:0] out_store_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_regwrite,
  output logic                  out_memread,
  output logic                  out_memwrite,
  output logic                  out_br_taken
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic [DATA_WIDTH-1:0] store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
    logic                  br_taken;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t cap_c;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   in_xfer_c, out_xfer_c;

  // Entries that are not valid keep their data but carry no side effects.
  function automatic entry_t clear_ctrl(input entry_t e);
    entry_t r;
    r          = e;
    r.regwrite = 1'b0;
    r.memread  = 1'b0;
    r.memwrite = 1'b0;
    r.br_taken = 1'b0;
    return r;
  endfunction

  always_comb begin
    cap_c            = '0;
    cap_c.result     = in_result;
    cap_c.zero       = in_zero;
    cap_c.store_data = in_store_data;
    cap_c.rd         = in_rd;
    cap_c.regwrite   = in_regwrite & (in_rd != '0);
    cap_c.memread    = in_memread;
    cap_c.memwrite   = in_memwrite;
    cap_c.br_taken   = in_branch & (in_bne ? ~in_zero : in_zero);
  end

  assign in_xfer_c  = in_valid & in_ready_q;
  assign out_xfer_c = out_valid_q & out_ready;

  // Next-state: flush overrides every transfer in the same cycle.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = clear_ctrl(head_q);
      skid_d  = clear_ctrl(skid_q);
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer_c) begin
            head_d  = cap_c;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_xfer_c && out_xfer_c) begin
            head_d = cap_c;
          end else if (in_xfer_c) begin
            skid_d  = cap_c;
            state_d = FULL;
          end else if (out_xfer_c) begin
            head_d  = clear_ctrl(head_q);
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer_c) begin
            head_d  = skid_q;
            skid_d  = clear_ctrl(skid_q);
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = clear_ctrl(head_q);
          skid_d  = clear_ctrl(skid_q);
        end
      endcase
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_result     = head_q.result;
  assign out_zero       = head_q.zero;
  assign out_store_data = head_q.store_data;
  assign out_rd         = head_q.rd;
  assign out_regwrite   = head_q.regwrite;
  assign out_memread    = head_q.memread;
  assign out_memwrite   = head_q.memwrite;
  assign out_br_taken   = head_q.br_taken;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of cycles MEM refuses a valid head; survives flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else if (out_valid_q && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Randomized scoreboard bench for ex_mem_skid_stage plus directed boundary cases.
module tb_ex_mem_skid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_zero;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        in_regwrite, in_memread, in_memwrite, in_branch, in_bne;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_regwrite, out_memread, out_memwrite, out_br_taken;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  ex_mem_skid_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .in_memread(in_memread),
    .in_memwrite(in_memwrite), .in_branch(in_branch), .in_bne(in_bne),
`ifdef EX_MEM_STALL_CNT_EN
    .stall_count(stall_count),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_regwrite(out_regwrite), .out_memread(out_memread),
    .out_memwrite(out_memwrite), .out_br_taken(out_br_taken)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        br_taken;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   occ     = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic exp_t model(input logic [31:0] res, input logic z, input logic [31:0] sd,
                                 input logic [4:0] rd, input bit rw, input bit mr,
                                 input bit mw, input bit br, input bit bne);
    exp_t e;
    e.result     = res;
    e.zero       = z;
    e.store_data = sd;
    e.rd         = rd;
    e.regwrite   = rw && (rd != 5'd0);
    e.memread    = mr;
    e.memwrite   = mw;
    if (!br)     e.br_taken = 1'b0;
    else if (bne) e.br_taken = (z == 1'b0);
    else          e.br_taken = (z == 1'b1);
    return e;
  endfunction

  // Drive one cycle of inputs; the expected entry is queued when the bench sees an accept.
  task automatic step(input bit v, input logic [31:0] res, input logic [4:0] rd, input bit z,
                      input bit rw, input bit mr, input bit mw, input bit br, input bit bne,
                      input bit ordy, input bit fl);
    in_valid      = v;
    in_result     = res;
    in_store_data = res ^ 32'hA5A5_5A5A;
    in_rd         = rd;
    in_zero       = z;
    in_regwrite   = rw;
    in_memread    = mr;
    in_memwrite   = mw;
    in_branch     = br;
    in_bne        = bne;
    out_ready     = ordy;
    flush         = fl;
    if (rst || fl) q.delete();
    else if (v && in_ready) q.push_back(model(res, z, res ^ 32'hA5A5_5A5A, rd, rw, mr, mw, br, bne));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  task automatic push(input logic [31:0] res, input logic [4:0] rd, input bit ordy);
    step(1'b1, res, rd, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  // Monitor: occupancy model for handshake outputs, scoreboard pop on each output transfer.
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (rst) begin
      occ = 0;
    end else begin
      chk("out_valid", 128'(out_valid), 128'(occ != 0));
      chk("in_ready", 128'(in_ready), 128'(occ < 2));
      if (out_valid && out_ready && !flush) begin
        act.result     = out_result;
        act.zero       = out_zero;
        act.store_data = out_store_data;
        act.rd         = out_rd;
        act.regwrite   = out_regwrite;
        act.memread    = out_memread;
        act.memwrite   = out_memwrite;
        act.br_taken   = out_br_taken;
        if (q.size() == 0) begin
          chk("unexpected_output", 128'(act), 128'(0));
        end else begin
          e = q.pop_front();
          chk("head_entry", 128'(act), 128'(e));
        end
      end
      if (flush) occ = 0;
      else occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_result = '0; in_store_data = '0; in_rd = '0; in_zero = 1'b0;
    in_regwrite = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0; in_branch = 1'b0;
    in_bne = 1'b0; out_ready = 1'b0; flush = 1'b0;

    // Reset values
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_result", 128'(out_result), 128'(0));
    chk("rst_out_ctrl", 128'({out_regwrite, out_memread, out_memwrite, out_br_taken, out_zero}), 128'(0));

    push(32'h0000_0005, 5'd3, 1'b1);
    chk("first_valid", 128'(out_valid), 128'(1));
    chk("first_result", 128'(out_result), 128'(5));
    chk("first_regwrite", 128'(out_regwrite), 128'(1));

    // Full-throughput stream
    for (int i = 1; i <= 8; i++) begin
      push(32'(i), 5'(i), 1'b1);
      chk("stream_in_ready", 128'(in_ready), 128'(1));
      chk("stream_result", 128'(out_result), 128'(i));
    end
    idle(1'b1);

    // Back-pressure fills the skid register
    push(32'h11, 5'd1, 1'b0);
    push(32'h22, 5'd2, 1'b0);
    chk("full_in_ready", 128'(in_ready), 128'(0));
    chk("full_hold_a", 128'(out_result), 128'(32'h11));
    idle(1'b0);
    chk("stall_hold_a", 128'(out_result), 128'(32'h11));
    idle(1'b1);
    chk("skid_to_head_b", 128'(out_result), 128'(32'h22));
    chk("drain_in_ready", 128'(in_ready), 128'(1));
    idle(1'b1);
    chk("drained_valid", 128'(out_valid), 128'(0));

    // Branch resolution and r0 write suppression
    step(1'b1, 32'h100, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("beq_zero1", 128'(out_br_taken), 128'(1));
    step(1'b1, 32'h104, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("bne_zero1", 128'(out_br_taken), 128'(0));
    step(1'b1, 32'h108, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("bne_zero0", 128'(out_br_taken), 128'(1));
    push(32'h10C, 5'd0, 1'b1);
    chk("r0_regwrite", 128'(out_regwrite), 128'(0));
    idle(1'b1);

    // Flush while full and while holding one entry
    push(32'h44, 5'd5, 1'b0);
    push(32'h55, 5'd6, 1'b0);
    step(1'b1, 32'h33, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flush_full_valid", 128'(out_valid), 128'(0));
    chk("flush_full_in_ready", 128'(in_ready), 128'(1));
    chk("flush_ctrl", 128'({out_regwrite, out_memread, out_memwrite, out_br_taken}), 128'(0));
    push(32'h66, 5'd8, 1'b0);
    step(1'b1, 32'h77, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_one_valid", 128'(out_valid), 128'(0));
    idle(1'b1);
    chk("flush_drop_valid", 128'(out_valid), 128'(0));

    // Randomized traffic with occasional flush
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 7), $urandom, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("scoreboard_empty", 128'(q.size()), 128'(0));
    chk("final_valid", 128'(out_valid), 128'(0));

`ifdef EX_MEM_STALL_CNT_EN
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    chk("stall_cnt_rst", 128'(stall_count), 128'(0));
    push(32'h99, 5'd1, 1'b0);
    for (int k = 0; k < 10; k++) idle(1'b0);
    chk("stall_cnt_10", 128'(stall_count), 128'(10));
    step(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("stall_cnt_flush", 128'(stall_count), 128'(10));
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    chk("stall_cnt_rst2", 128'(stall_count), 128'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
